text_buffer: RTL and testbench
==============================

Name: text_buffer

Overview:
- Character-cell text store for the centre text window: 32 columns x 4 rows of 8x16 glyph cells at x 192..447, y 208..271.
- Write side accepts a byte stream through a valid/ready handshake, from the keyboard/UART front end. Bit 7 selects the Thai glyph set and is stored verbatim.
- Read side turns the current pixel coordinate into the `ascii_code` byte consumed by the glyph renderer.
- Handles cursor advance, newline, backspace, clear-screen and wrap-around.

Parameters:
- COLS, 32, characters per row (power of two).
- ROWS, 4, text rows (power of two).
- X0, 192, left pixel edge of the text window.
- Y0, 208, top pixel edge of the text window.
- BLANK, 8'h20, fill code used for clear and backspace.

Ports:
- clk  in  1  pixel-domain system clock.
- rst_n  in  1  asynchronous, active-low reset.
- char_valid  in  1  write byte present.
- char_data  in  8  byte to write; printable or control code.
- char_ready  out  1  buffer can accept a byte this cycle.
- x  in  10  current pixel column from the sync generator.
- y  in  10  current pixel row from the sync generator.
- ascii_code  out  8  glyph code for the cell under (x,y); registered.
- cursor  out  7  linear cell index of the next write, {row[1:0],col[4:0]}.
- busy  out  1  clear sweep in progress.

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0: cursor=0, ascii_code=BLANK, state=CLEAR, clr_addr=0, char_ready=0, busy=1. Cell RAM contents are not reset.
- FSM states: CLEAR, IDLE.
- CLEAR:
  - Writes BLANK to cell clr_addr each cycle, then clr_addr++.
  - After cell 127 is written, go to IDLE and set cursor=0. The sweep is exactly 128 cycles.
  - char_ready=0 and busy=1 throughout.
- IDLE: char_ready=1, busy=0. A transfer occurs on a rising edge with char_valid&&char_ready, and one byte is handled per cycle. Actions by byte:
  - 8'h0D or 8'h0A (newline): cursor = {row+1 mod ROWS, 5'd0}. No RAM write. From row 3 it wraps to row 0.
  - 8'h08 (backspace): if cursor!=0, cursor-1 and write BLANK at the new cursor. If cursor==0, no action.
  - 8'h0C (form feed): go to CLEAR at the next edge; char_ready drops the following cycle.
  - Any other byte, including bit7=1 Thai codes: write char_data at cursor, then cursor+1 mod 128. From 127 it wraps to 0 with no scroll.
  - char_valid with char_ready=0: byte is held by the producer; nothing is dropped or consumed.
- Read path:
  - col = (x-X0)>>3 and row = (y-Y0)>>4 when X0<=x<X0+256 and Y0<=y<Y0+64. The RAM is read at {row,col}.
  - ascii_code is registered with 1-cycle latency from x/y.
  - Outside the window the registered value is BLANK.
  - During CLEAR the read path stays live and shows partially cleared contents.
- Simultaneous write and read of the same cell is read-first: ascii_code shows the old byte that cycle and the new byte on the next access.
- Reset asserted mid-CLEAR or mid-write: the write is aborted, and the sweep restarts from 0 after release.
- All cursor arithmetic is 7-bit modulo; row = cursor[6:5], col = cursor[4:0].

Decomposition:
- Shared package text_pkg holds:
  - constants COLS, ROWS, X0, Y0, BLANK;
  - control codes CC_BS=8'h08, CC_LF=8'h0A, CC_FF=8'h0C, CC_CR=8'h0D;
  - state enum {CLEAR, IDLE}.
- One sub-module, text_ram: 128x8 simple dual-port RAM. It has one synchronous write port and one synchronous read-first read port, with no reset, so it infers block or distributed RAM.

Test Plan:
- Reset release:
  - busy=1 and char_ready=0 for exactly 128 cycles, then busy=0 and cursor=0.
  - Scanning (x=192..447, y=208..271) returns 8'h20 for every cell.
- Write "HI" then 8'hA1:
  - cursor=3.
  - At x=192,y=208 ascii_code=8'h48 one cycle later; x=200 gives 8'h49; x=208 gives 8'hA1.
  - At x=100,y=100 ascii_code=8'h20.
- Newline handling:
  - Write 8'h0D at cursor=3 -> cursor=32. Write 'A' -> cell 32 (x=192,y=224) = 8'h41.
  - From cursor=100, 8'h0A -> cursor=0.
- Backspace:
  - At cursor=3, 8'h08 -> cursor=2 and cell 2 = 8'h20.
  - At cursor=0, 8'h08 -> cursor stays 0 and no cell changes.
- Wrap: 128 consecutive 'Z' writes then 'Q' -> cursor=1, cell 0 = 8'h51, cell 127 = 8'h5A.
- Form feed:
  - 8'h0C -> char_ready=0 for 128 cycles; a held char_valid byte is accepted only after.
  - All cells are 8'h20 afterwards and cursor=0.
  - rst_n pulsed at sweep cycle 60 -> the sweep restarts and lasts a full 128 cycles.

Source files
------------

// File: rtl/text_buffer_pkg.sv
// Shared constants, control codes and state encoding for the text window buffer.
// 32x4 cells of 8x16 glyphs placed at pixel (192,208).
package text_pkg;

  localparam int unsigned COLS = 32;
  localparam int unsigned ROWS = 4;
  localparam int unsigned CELLS = COLS * ROWS;

  localparam logic [9:0] X0 = 10'd192;
  localparam logic [9:0] Y0 = 10'd208;
  localparam logic [9:0] X_END = 10'd448;  // X0 + COLS*8
  localparam logic [9:0] Y_END = 10'd272;  // Y0 + ROWS*16

  localparam logic [7:0] BLANK = 8'h20;

  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

endpackage

// File: rtl/text_ram.sv
// 128x8 simple dual-port cell store: one synchronous write port and one
// synchronous read-first read port.
module text_ram (
  input  logic       clk,
  input  logic       we,
  input  logic [6:0] waddr,
  input  logic [7:0] wdata,
  input  logic [6:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [128];

  // NOTE: the array has no reset so it maps onto block/distributed RAM; the
  // owner clears it with a sweep instead.
  // NOTE: non-blocking assignments make the read return the pre-write byte
  // when both ports hit the same cell (read-first).
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/text_buffer.sv
// Character-cell text buffer: byte-stream writer with cursor control on one
// side, pixel-coordinate to glyph-code lookup on the other.
module text_buffer
  import text_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  output logic       char_ready,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [7:0] ascii_code,
  output logic [6:0] cursor,
  output logic       busy
);

  state_t     state_q, state_d;
  logic [6:0] clr_addr_q, clr_addr_d;
  logic [6:0] cursor_q, cursor_d;

  logic       we;
  logic [6:0] waddr;
  logic [7:0] wdata;

  logic       in_win, in_win_q;
  logic [4:0] rd_col;
  logic [1:0] rd_row;
  logic [7:0] rd_data;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    cursor_d   = cursor_q;
    we         = 1'b0;
    waddr      = cursor_q;
    wdata      = char_data;
    char_ready = 1'b0;
    busy       = 1'b0;

    case (state_q)
      CLEAR: begin
        busy       = 1'b1;
        we         = 1'b1;
        waddr      = clr_addr_q;
        wdata      = BLANK;
        clr_addr_d = clr_addr_q + 7'd1;
        if (clr_addr_q == 7'd127) begin
          state_d  = IDLE;
          cursor_d = 7'd0;
        end
      end

      IDLE: begin
        char_ready = 1'b1;
        if (char_valid) begin
          case (char_data)
            CC_CR, CC_LF: begin
              cursor_d = {cursor_q[6:5] + 2'd1, 5'd0};
            end
            CC_BS: begin
              if (cursor_q != 7'd0) begin
                cursor_d = cursor_q - 7'd1;
                we       = 1'b1;
                waddr    = cursor_q - 7'd1;
                wdata    = BLANK;
              end
            end
            CC_FF: begin
              state_d    = CLEAR;
              clr_addr_d = 7'd0;
            end
            default: begin
              we       = 1'b1;
              cursor_d = cursor_q + 7'd1;
            end
          endcase
        end
      end

      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_addr_q <= 7'd0;
      cursor_q   <= 7'd0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      cursor_q   <= cursor_d;
    end
  end

  assign cursor = cursor_q;

  // Read side: window test and cell address come straight from the pixel
  // position; the window flag is delayed to line up with the RAM output.
  assign in_win = (x >= X0) && (x < X_END) && (y >= Y0) && (y < Y_END);
  assign rd_col = 5'((x - X0) >> 3);
  assign rd_row = 2'((y - Y0) >> 4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_win_q <= 1'b0;
    end else begin
      in_win_q <= in_win;
    end
  end

  assign ascii_code = in_win_q ? rd_data : BLANK;

  text_ram u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr ({rd_row, rd_col}),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_text_buffer.sv
// Scoreboard bench for text_buffer: a cell-array model predicts every glyph
// lookup; a monitor compares whenever a lookup result is due.
module tb_text_buffer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       char_valid = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic       char_ready;
  logic [9:0] x = 10'd0;
  logic [9:0] y = 10'd0;
  logic [7:0] ascii_code;
  logic [6:0] cursor;
  logic       busy;

  int total = 0;
  int bad = 0;

  logic [7:0] m_mem [128];
  int         m_cur;
  logic [7:0] exp_q [$];
  logic       probe = 1'b0;
  logic       probe_d = 1'b0;

  text_buffer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .x          (x),
    .y          (y),
    .ascii_code (ascii_code),
    .cursor     (cursor),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a lookup issued before edge N is due on ascii_code after edge N.
  always @(posedge clk) probe_d <= probe;

  always @(negedge clk) begin
    if (probe_d) begin
      if (exp_q.size() == 0) begin
        check("ascii_unexpected", 32'(ascii_code), 32'hFFFF_FFFF);
      end else begin
        check("ascii_code", 32'(ascii_code), 32'(exp_q.pop_front()));
      end
    end
  end

  // Reference model: the screen as an array of 128 bytes plus a linear cursor.
  function automatic void model_clear();
    for (int i = 0; i < 128; i++) m_mem[i] = 8'h20;
    m_cur = 0;
  endfunction

  function automatic void model_apply(input logic [7:0] b);
    if (b == 8'h0D || b == 8'h0A) begin
      m_cur = ((m_cur / 32 + 1) % 4) * 32;
    end else if (b == 8'h08) begin
      if (m_cur > 0) begin
        m_cur = m_cur - 1;
        m_mem[m_cur] = 8'h20;
      end
    end else if (b == 8'h0C) begin
      model_clear();
    end else begin
      m_mem[m_cur] = b;
      m_cur = (m_cur + 1) % 128;
    end
  endfunction

  function automatic logic [7:0] model_at(input int xi, input int yi);
    if (xi >= 192 && xi < 448 && yi >= 208 && yi < 272)
      return m_mem[((yi - 208) / 16) * 32 + (xi - 192) / 8];
    return 8'h20;
  endfunction

  // All driver tasks start and end one time unit after a rising edge.
  task automatic rd(input int xi, input int yi);
    x = 10'(xi);
    y = 10'(yi);
    probe = 1'b1;
    exp_q.push_back(model_at(xi, yi));
    @(posedge clk);
    #1;
    probe = 1'b0;
  endtask

  task automatic rd_cell(input int idx);
    rd(192 + (idx % 32) * 8 + int'($urandom_range(0, 7)),
       208 + (idx / 32) * 16 + int'($urandom_range(0, 15)));
  endtask

  task automatic scan();
    for (int i = 0; i < 128; i++) rd_cell(i);
    rd(100, 100);
    rd(191, 208);
    rd(448, 240);
    rd(300, 272);
    rd(300, 207);
  endtask

  task automatic send(input logic [7:0] b);
    int  n;
    logic ok;
    n = 0;
    ok = 1'b0;
    char_valid = 1'b1;
    char_data = b;
    while (!ok && n < 400) begin
      @(negedge clk);
      ok = char_ready;
      @(posedge clk);
      #1;
      n++;
    end
    char_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
    else model_apply(b);
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (!busy || n >= 400) break;
      n++;
    end
    check(name, 32'(n), 32'd128);
    check({name, "_cursor"}, 32'(cursor), 32'd0);
    check({name, "_ready"}, 32'(char_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] b;
    int n;
    model_clear();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_ready", 32'(char_ready), 32'd0);
    check("rst_cursor", 32'(cursor), 32'd0);
    check("rst_ascii", 32'(ascii_code), 32'h20);
    rst_n = 1'b1;
    count_busy("init_sweep");
    scan();

    // "HI" then a Thai code
    send(8'h48);
    send(8'h49);
    send(8'hA1);
    check("cursor_hi", 32'(cursor), 32'd3);
    rd(192, 208);
    rd(200, 208);
    rd(208, 208);
    rd(100, 100);

    // Newlines
    send(8'h0D);
    check("cursor_cr", 32'(cursor), 32'd32);
    send(8'h41);
    rd(192, 224);
    send(8'h0A);
    send(8'h0A);
    for (int i = 0; i < 4; i++) send(8'h30 + 8'(i));
    check("cursor_100", 32'(cursor), 32'd100);
    send(8'h0A);
    check("cursor_lf_wrap", 32'(cursor), 32'd0);

    // Backspace at the origin does nothing; elsewhere it blanks the cell
    send(8'h08);
    check("cursor_bs0", 32'(cursor), 32'd0);
    scan();
    for (int i = 0; i < 3; i++) send(8'h61 + 8'(i));
    check("cursor_pre_bs", 32'(cursor), 32'd3);
    send(8'h08);
    check("cursor_bs", 32'(cursor), 32'd2);
    rd_cell(2);
    rd_cell(1);

    // Wrap with no scroll
    repeat (4) send(8'h0A);
    check("cursor_home", 32'(cursor), 32'd0);
    repeat (128) send(8'h5A);
    send(8'h51);
    check("cursor_wrap", 32'(cursor), 32'd1);
    rd_cell(0);
    rd_cell(127);

    // Random byte stream interleaved with random pixel lookups
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0: b = 8'h0D;
        1: b = 8'h0A;
        2: b = 8'h08;
        default: begin
          b = 8'($urandom_range(0, 255));
          if (b == 8'h08 || b == 8'h0A || b == 8'h0C || b == 8'h0D) b = 8'hE0;
        end
      endcase
      send(b);
      check("cursor_rand", 32'(cursor), 32'(m_cur));
      rd(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
    end
    scan();

    // Form feed with a byte held waiting by the producer
    send(8'h0C);
    char_valid = 1'b1;
    char_data = 8'h4B;
    n = 0;
    forever begin
      @(negedge clk);
      if (char_ready || n >= 400) break;
      n++;
    end
    check("ff_ready_low", 32'(n), 32'd128);
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    model_apply(8'h4B);
    check("cursor_after_ff", 32'(cursor), 32'd1);
    scan();

    // Reset pulse in the middle of a sweep restarts it from cell 0
    send(8'h0C);
    repeat (60) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd1);
    check("midrst_ready", 32'(char_ready), 32'd0);
    check("midrst_ascii", 32'(ascii_code), 32'h20);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    count_busy("restart_sweep");
    scan();

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
